// File: rtl/rr_count_pkg.sv
// Shared types and helpers for the round-robin count scheduler.
package rr_count_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WRAP = 2'd2
    } state_t;

    localparam int NREQ_DEF  = 4;
    localparam int WIDTH_DEF = 8;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int IDW = idx_w(NREQ_DEF);

endpackage

// File: rtl/rr_count_sched_if.sv
// Request/grant bundle between requesters and the count scheduler.
interface rr_count_sched_if
    import rr_count_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int WIDTH = WIDTH_DEF
);
    localparam int IW = idx_w(NREQ);

    logic             en;
    logic [NREQ-1:0]  req;
    logic [NREQ-1:0]  grant;
    logic [IW-1:0]    grant_id;
    logic [WIDTH-1:0] count;
    logic             wrap;
    logic             busy;

    modport master (
        output en, req,
        input  grant, grant_id, count, wrap, busy
    );

    modport slave (
        input  en, req,
        output grant, grant_id, count, wrap, busy
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set req bit from ptr upward.
module rr_pick
    import rr_count_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
) (
    input  logic [NREQ-1:0]        req,
    input  logic [idx_w(NREQ)-1:0] ptr,
    output logic                   valid,
    output logic [idx_w(NREQ)-1:0] sel
);
    localparam int IW = idx_w(NREQ);

    int unsigned j;

    // Scan from lowest priority to highest so the last hit wins.
    always_comb begin
        valid = 1'b0;
        sel   = '0;
        j     = 0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= NREQ) j = j - NREQ;
            if (req[j]) begin
                valid = 1'b1;
                sel   = IW'(j);
            end
        end
    end

endmodule

// File: rtl/rr_count_sched.sv
// Round-robin scheduler sharing one bounded wrap-around counter.
module rr_count_sched
    import rr_count_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int LIMIT = 5,
    parameter int NREQ  = NREQ_DEF
) (
    input logic             clk,
    input logic             rst,
    rr_count_sched_if.slave bus
);
    localparam int IW = idx_w(NREQ);
    localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);
    localparam logic [NREQ-1:0]  ONE = NREQ'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [NREQ-1:0]  grant_q, grant_d;
    logic [IW-1:0]    grant_id_q, grant_id_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic             wrap_q, wrap_d;
    logic             busy_q, busy_d;
    logic [NREQ-1:0]  req_prev_q;

    logic             pick_valid;
    logic [IW-1:0]    pick_sel;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req   (bus.req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .sel   (pick_sel)
    );

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        grant_d    = '0;
        grant_id_d = grant_id_q;
        ptr_d      = ptr_q;
        wrap_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.en) state_d = RUN;
            end
            RUN: begin
                if (!bus.en) begin
                    state_d = IDLE;
                end else if (count_q == LIM) begin
                    state_d = WRAP;
                    count_d = '0;
                    wrap_d  = 1'b1;
                end else if (pick_valid) begin
                    grant_d    = ONE << pick_sel;
                    grant_id_d = pick_sel;
                    count_d    = count_q + 1'b1;
                    ptr_d      = (pick_sel == IW'(NREQ - 1))
                               ? '0 : pick_sel + 1'b1;
                end
            end
            WRAP: begin
                count_d = '0;
                state_d = bus.en ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            grant_q    <= '0;
            grant_id_q <= '0;
            ptr_q      <= '0;
            wrap_q     <= 1'b0;
            busy_q     <= 1'b0;
            req_prev_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            ptr_q      <= ptr_d;
            wrap_q     <= wrap_d;
            busy_q     <= busy_d;
            req_prev_q <= bus.req;
        end
    end

    // req_prev_q still holds the request vector that produced grant_q.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (count_q <= LIM);
            assert ($onehot0(grant_q));
            assert (grant_q == '0 || (state_q == RUN && count_q != '0));
            assert (!wrap_q || (count_q == '0 && grant_q == '0));
            assert ((grant_q & ~req_prev_q) == '0);
        end
    end

    assign bus.grant    = grant_q;
    assign bus.grant_id = grant_id_q;
    assign bus.count    = count_q;
    assign bus.wrap     = wrap_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_rr_count_sched.sv
// Directed bench for rr_count_sched with hand-computed expectations.
module tb_rr_count_sched;
    import rr_count_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   total  = 0;
    int   passed = 0;

    rr_count_sched_if #(.NREQ(4), .WIDTH(8)) bus ();

    rr_count_sched #(.WIDTH(8), .LIMIT(5), .NREQ(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic st(input string tag, input logic [3:0] g,
                      input logic [7:0] c, input logic w, input logic b);
        chk({tag, ".grant"}, 32'(bus.grant), 32'(g));
        chk({tag, ".count"}, 32'(bus.count), 32'(c));
        chk({tag, ".wrap"},  32'(bus.wrap),  32'(w));
        chk({tag, ".busy"},  32'(bus.busy),  32'(b));
    endtask

    logic [3:0] rr_g [13] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                              4'b0001, 4'b0000, 4'b0000, 4'b0010,
                              4'b0100, 4'b1000, 4'b0001, 4'b0010,
                              4'b0000};
    logic [7:0] rr_c [13] = '{1, 2, 3, 4, 5, 0, 0, 1, 2, 3, 4, 5, 0};
    logic       rr_w [13] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1};

    initial begin
        rst     = 1'b1;
        bus.en  = 1'b1;
        bus.req = 4'b1111;
        tick();
        tick();
        st("reset", 4'b0000, 8'd0, 1'b0, 1'b0);
        chk("reset.grant_id", 32'(bus.grant_id), 32'd0);

        rst = 1'b0;
        tick();
        st("rr.e1", 4'b0000, 8'd0, 1'b0, 1'b1);
        for (int i = 0; i < 13; i++) begin
            tick();
            st($sformatf("rr.e%0d", i + 2), rr_g[i], rr_c[i], rr_w[i], 1'b1);
        end

        // Reset lands while a wrap is pending.
        rst     = 1'b1;
        bus.req = 4'b0001;
        tick();
        st("rst_wrap", 4'b0000, 8'd0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        st("single.e1", 4'b0000, 8'd0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            st($sformatf("single.e%0d", i + 2), 4'b0001, 8'(i + 1), 1'b0, 1'b1);
            chk("single.grant_id", 32'(bus.grant_id), 32'd0);
        end
        tick();
        st("single.e7", 4'b0000, 8'd0, 1'b1, 1'b1);
        tick();
        st("single.e8", 4'b0000, 8'd0, 1'b0, 1'b1);
        tick();
        st("single.e9", 4'b0001, 8'd1, 1'b0, 1'b1);
        tick();
        st("single.e10", 4'b0001, 8'd2, 1'b0, 1'b1);
        tick();
        st("single.e11", 4'b0001, 8'd3, 1'b0, 1'b1);

        bus.en  = 1'b0;
        bus.req = 4'b1010;
        tick();
        st("en_drop", 4'b0000, 8'd3, 1'b0, 1'b0);
        bus.en = 1'b1;
        tick();
        st("en_idle_run", 4'b0000, 8'd3, 1'b0, 1'b1);
        tick();
        st("en_resume", 4'b0010, 8'd4, 1'b0, 1'b1);
        chk("en_resume.grant_id", 32'(bus.grant_id), 32'd1);

        bus.req = 4'b1000;
        tick();
        st("to_limit", 4'b1000, 8'd5, 1'b0, 1'b1);
        chk("to_limit.grant_id", 32'(bus.grant_id), 32'd3);
        bus.req = 4'b0100;
        tick();
        st("req_on_limit", 4'b0000, 8'd0, 1'b1, 1'b1);
        chk("req_on_limit.grant_id", 32'(bus.grant_id), 32'd3);
        tick();
        st("req_on_wrap", 4'b0000, 8'd0, 1'b0, 1'b1);
        tick();
        st("req_after_wrap", 4'b0100, 8'd1, 1'b0, 1'b1);
        chk("req_after_wrap.grant_id", 32'(bus.grant_id), 32'd2);
        for (int i = 2; i <= 4; i++) begin
            tick();
            st($sformatf("hold2.c%0d", i), 4'b0100, 8'(i), 1'b0, 1'b1);
        end

        rst     = 1'b1;
        bus.req = 4'b1010;
        tick();
        st("mid_rst", 4'b0000, 8'd0, 1'b0, 1'b0);
        chk("mid_rst.grant_id", 32'(bus.grant_id), 32'd0);
        rst = 1'b0;
        tick();
        st("post_rst.e1", 4'b0000, 8'd0, 1'b0, 1'b1);
        tick();
        st("post_rst.e2", 4'b0010, 8'd1, 1'b0, 1'b1);
        chk("post_rst.grant_id", 32'(bus.grant_id), 32'(IDW'(1)));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
